// File: rtl/rca_stim_checker.sv
// Self-checking stimulus engine for a ripple-carry adder: issues exhaustive or LFSR operand
// vectors and compares the adder's {carry_out,sum} with a + b + carry_in after LATENCY cycles.
module rca_stim_checker #(
    parameter int          WIDTH       = 4,
    parameter int          LATENCY     = 0,
    parameter int          MODE        = 0,
    parameter int          NUM_VECTORS = 64,
    parameter logic [31:0] SEED        = 32'h1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   b,
    output logic               carry_in,
    output logic               valid_out,
    input  logic [WIDTH-1:0]   sum,
    input  logic               carry_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [15:0]        err_count,
    output logic [2*WIDTH+1:0] vec_count
);
    localparam int VW = 2 * WIDTH + 1;
    localparam int CW = (VW + 1 > 17) ? VW + 1 : 17;
    localparam int GW = (VW > 32) ? VW : 32;
    localparam logic [CW-1:0] N = (MODE == 0) ? (CW'(1) << VW) : CW'(NUM_VECTORS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state, state_next;
    logic [GW-1:0]   gen, gen_first, gen_next;
    logic [CW-1:0]   issue_cnt;
    logic            start_run, last_issued;
    logic [WIDTH:0]  expected;
    logic            cmp_valid, pending, mismatch;
    logic [WIDTH:0]  cmp_exp;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    assign start_run   = start && (state == IDLE || state == DONE);
    assign last_issued = (issue_cnt == N);
    assign gen_first   = (MODE == 1) ? GW'(SEED) : '0;

    always_comb begin
        if (MODE == 1) gen_next = GW'(lfsr_step(gen[31:0]));
        else           gen_next = gen + {{(GW-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_issued) state_next = DRAIN;
            DRAIN:   if (!pending) state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // The generator register always holds the vector currently on a/b/carry_in.
    always_ff @(posedge clk) begin
        if (rst) begin
            gen              <= gen_first;
            {carry_in, b, a} <= '0;
            valid_out        <= 1'b0;
            issue_cnt        <= '0;
        end else if (start_run) begin
            gen              <= gen_first;
            {carry_in, b, a} <= gen_first[VW-1:0];
            valid_out        <= 1'b1;
            issue_cnt        <= {{(CW-1){1'b0}}, 1'b1};
        end else if (state == RUN) begin
            if (last_issued) begin
                valid_out <= 1'b0;
            end else begin
                gen              <= gen_next;
                {carry_in, b, a} <= gen_next[VW-1:0];
                issue_cnt        <= issue_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign expected = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};

    generate
        if (LATENCY == 0) begin : g_nodelay
            assign cmp_valid = valid_out;
            assign cmp_exp   = expected;
            assign pending   = 1'b0;
        end else begin : g_delay
            logic [LATENCY-1:0] dv;
            logic [WIDTH:0]     de [LATENCY];

            always_ff @(posedge clk) begin
                if (rst || start_run) begin
                    for (int i = 0; i < LATENCY; i++) begin
                        dv[i] <= 1'b0;
                        de[i] <= '0;
                    end
                end else begin
                    dv[0] <= valid_out;
                    de[0] <= expected;
                    for (int i = 1; i < LATENCY; i++) begin
                        dv[i] <= dv[i-1];
                        de[i] <= de[i-1];
                    end
                end
            end

            assign cmp_valid = dv[LATENCY-1];
            assign cmp_exp   = de[LATENCY-1];
            assign pending   = |dv;
        end
    endgenerate

    // Case inequality so an X or Z from the adder counts as a mismatch.
    assign mismatch = ({carry_out, sum} !== cmp_exp);

    always_ff @(posedge clk) begin
        if (rst || start_run) begin
            err_count <= '0;
            vec_count <= '0;
        end else if (cmp_valid) begin
            vec_count <= vec_count + {{(2*WIDTH+1){1'b0}}, 1'b1};
            if (mismatch && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = done && (err_count == 16'd0);

endmodule

// File: tb/tb_rca_stim_checker.sv
// Bench for rca_stim_checker: three instances (2-bit comb with optional stuck bit, 4-bit
// two-stage pipelined, 4-bit LFSR) checked every cycle against a cycle-indexed reference model.
module tb_rca_stim_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] start_vec;
    logic       fault;

    // Instance 0: WIDTH=2, LATENCY=0, exhaustive, combinational adder with optional sum[0] stuck-at-0
    logic [1:0]  a0, b0, sum0;
    logic        cin0, v0, co0, busy0, done0, pass0;
    logic [15:0] err0;
    logic [5:0]  vc0;
    logic [2:0]  raw0;
    assign raw0 = {1'b0, a0} + {1'b0, b0} + {2'b0, cin0};
    assign sum0 = fault ? {raw0[1], 1'b0} : raw0[1:0];
    assign co0  = raw0[2];

    rca_stim_checker #(.WIDTH(2), .LATENCY(0), .MODE(0)) u0 (
        .clk(clk), .rst(rst), .start(start_vec[0]), .a(a0), .b(b0), .carry_in(cin0),
        .valid_out(v0), .sum(sum0), .carry_out(co0), .busy(busy0), .done(done0),
        .pass(pass0), .err_count(err0), .vec_count(vc0));

    // Instance 1: WIDTH=4, LATENCY=2, exhaustive, two-stage registered adder
    logic [3:0]  a1, b1, sum1;
    logic        cin1, v1, co1, busy1, done1, pass1;
    logic [15:0] err1;
    logic [9:0]  vc1;
    logic [4:0]  p1, p2;
    always @(posedge clk) begin
        p1 <= {1'b0, a1} + {1'b0, b1} + {4'b0, cin1};
        p2 <= p1;
    end
    assign {co1, sum1} = p2;

    rca_stim_checker #(.WIDTH(4), .LATENCY(2), .MODE(0)) u1 (
        .clk(clk), .rst(rst), .start(start_vec[1]), .a(a1), .b(b1), .carry_in(cin1),
        .valid_out(v1), .sum(sum1), .carry_out(co1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err1), .vec_count(vc1));

    // Instance 2: WIDTH=4, LATENCY=0, LFSR mode, 64 vectors, seed 1
    logic [3:0]  a2, b2, sum2;
    logic        cin2, v2, co2, busy2, done2, pass2;
    logic [15:0] err2;
    logic [9:0]  vc2;
    assign {co2, sum2} = {1'b0, a2} + {1'b0, b2} + {4'b0, cin2};

    rca_stim_checker #(.WIDTH(4), .LATENCY(0), .MODE(1), .NUM_VECTORS(64), .SEED(32'h1)) u2 (
        .clk(clk), .rst(rst), .start(start_vec[2]), .a(a2), .b(b2), .carry_in(cin2),
        .valid_out(v2), .sum(sum2), .carry_out(co2), .busy(busy2), .done(done2),
        .pass(pass2), .err_count(err2), .vec_count(vc2));

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          check_en = 1'b0;
    int          nv[3]  = '{32, 512, 64};
    int          lat[3] = '{0, 2, 0};
    int          k[3]   = '{-1, -1, -1};
    int          exp_vc[3]  = '{0, 0, 0};
    int          exp_err[3] = '{0, 0, 0};
    logic [31:0] lfsr_tab[64];

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Vector j of a run, as the packed value {carry_in,b,a}
    function automatic logic [11:0] vec_of(input int inst, input int j);
        if (inst == 2) return {3'b0, lfsr_tab[j][8:0]};
        return 12'(j);
    endfunction

    function automatic bit sum_lsb0(input int j);
        int av, bv, cv;
        av = j % 4;
        bv = (j / 4) % 4;
        cv = j / 16;
        return ((av + bv + cv) % 2) == 1;
    endfunction

    // k = cycles since the start edge (1 = first vector on the outputs), -1 after reset
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                k[i] <= -1; exp_vc[i] <= 0; exp_err[i] <= 0;
            end else if ((k[i] < 0 || k[i] >= nv[i] + lat[i] + 2) && start_vec[i]) begin
                k[i] <= 1; exp_vc[i] <= 0; exp_err[i] <= 0;
            end else if (k[i] >= 1) begin
                if (k[i] - lat[i] >= 1 && k[i] - lat[i] <= nv[i]) begin
                    exp_vc[i] <= exp_vc[i] + 1;
                    if (i == 0 && fault && sum_lsb0(k[i] - lat[i] - 1))
                        exp_err[i] <= exp_err[i] + 1;
                end
                if (k[i] < nv[i] + lat[i] + 2) k[i] <= k[i] + 1;
            end
        end
    end

    function automatic logic [43:0] exp_pack(input int i);
        int n, l, kk;
        logic bz, dn, ps, vl;
        logic [11:0] vec;
        n = nv[i]; l = lat[i]; kk = k[i];
        bz = 1'b0; dn = 1'b0; ps = 1'b0; vl = 1'b0; vec = '0;
        if (kk >= 1) begin
            vl  = (kk <= n);
            vec = vec_of(i, (kk <= n) ? kk - 1 : n - 1);
            dn  = (kk >= n + l + 2);
            bz  = !dn;
            ps  = dn && (exp_err[i] == 0);
        end
        return {bz, dn, ps, vl, vec, 12'(exp_vc[i]), 16'(exp_err[i])};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("inst0", 64'({busy0, done0, pass0, v0, {7'b0, cin0, b0, a0}, {6'b0, vc0}, err0}), 64'(exp_pack(0)));
            checkOutput("inst1", 64'({busy1, done1, pass1, v1, {3'b0, cin1, b1, a1}, {2'b0, vc1}, err1}), 64'(exp_pack(1)));
            checkOutput("inst2", 64'({busy2, done2, pass2, v2, {3'b0, cin2, b2, a2}, {2'b0, vc2}, err2}), 64'(exp_pack(2)));
        end
    end

    function automatic logic done_of(input int i);
        return (i == 0) ? done0 : (i == 1) ? done1 : done2;
    endfunction

    // One-cycle start pulse; returns at the negedge of the first vector cycle
    task automatic applyStimulus(input int i, output int t0);
        t0 = cyc;
        start_vec[i] = 1'b1;
        @(negedge clk);
        start_vec[i] = 1'b0;
    endtask

    task automatic finish_run(input int i, input int t0, input int req_delta,
                              input int req_vc, input int req_err, input bit req_pass);
        int budget;
        logic [9:0]  vc;
        logic [15:0] er;
        logic        ps;
        budget = 2000;
        while (!done_of(i) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) checkOutput("done_timeout", 64'(0), 64'(1));
        vc = (i == 0) ? {4'b0, vc0} : (i == 1) ? vc1 : vc2;
        er = (i == 0) ? err0 : (i == 1) ? err1 : err2;
        ps = (i == 0) ? pass0 : (i == 1) ? pass1 : pass2;
        checkOutput("done_latency", 64'(cyc - t0), 64'(req_delta));
        checkOutput("vec_count", 64'(vc), 64'(req_vc));
        checkOutput("err_count", 64'(er), 64'(req_err));
        checkOutput("pass", 64'(ps), 64'(req_pass));
    endtask

    initial begin
        int t0;
        logic [31:0] s;
        rst = 1'b1; start_vec = '0; fault = 1'b0;
        s = 32'h1;
        for (int j = 0; j < 64; j++) begin
            lfsr_tab[j] = s;
            s = lfsr_next(s);
        end
        @(negedge clk);
        check_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Clean 2-bit exhaustive run
        applyStimulus(0, t0);
        finish_run(0, t0, 34, 32, 0, 1'b1);

        // Stuck sum[0]: half of the 32 vectors have an odd sum; restart from DONE
        fault = 1'b1;
        repeat (3) @(negedge clk);
        applyStimulus(0, t0);
        finish_run(0, t0, 34, 32, 16, 1'b0);
        fault = 1'b0;

        // Reset while the 10th vector is on the outputs, then a clean rerun
        applyStimulus(0, t0);
        repeat (9) @(negedge clk);
        checkOutput("tenth_vector", 64'({cin0, b0, a0}), 64'(9));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_zero", 64'({busy0, done0, pass0, v0, cin0, b0, a0, vc0, err0}), 64'(0));
        @(negedge clk);
        applyStimulus(0, t0);
        finish_run(0, t0, 34, 32, 0, 1'b1);

        // Pipelined adder with stray start pulses during RUN
        applyStimulus(1, t0);
        repeat (5) @(negedge clk);
        start_vec[1] = 1'b1;
        @(negedge clk);
        start_vec[1] = 1'b0;
        repeat (100) @(negedge clk);
        start_vec[1] = 1'b1;
        @(negedge clk);
        start_vec[1] = 1'b0;
        finish_run(1, t0, 516, 512, 0, 1'b1);

        // LFSR run: seed 1 gives a = 1, 3, 2, 1 with b = carry_in = 0
        applyStimulus(2, t0);
        checkOutput("lfsr_vec0", 64'({cin2, b2, a2}), 64'(9'h001));
        @(negedge clk);
        checkOutput("lfsr_vec1", 64'({cin2, b2, a2}), 64'(9'h003));
        @(negedge clk);
        checkOutput("lfsr_vec2", 64'({cin2, b2, a2}), 64'(9'h002));
        @(negedge clk);
        checkOutput("lfsr_vec3", 64'({cin2, b2, a2}), 64'(9'h001));
        finish_run(2, t0, 66, 64, 0, 1'b1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
